// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller: FSM states,
// access kinds, load/store opcodes and default widths.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_PC_W        = 8;
  localparam int DEF_OP_W        = 4;
  localparam int DEF_WAIT_STATES = 1;
  localparam int WAIT_CNT_W      = 4;

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

endpackage

// File: rtl/wait_counter.sv
// Down-counter for RAM wait states: loaded when an access is accepted,
// decremented while the access is in flight, done when it reaches zero.
module wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int CNT_W = WAIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             cnt_en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetches and execute-stage loads/stores onto one RAM
// port; non-memory execute requests bypass RAM and write back the ALU result.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              ADDR_W      = DEF_ADDR_W,
  parameter int              PC_W        = DEF_PC_W,
  parameter int              OP_W        = DEF_OP_W,
  parameter int              WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [OP_W-1:0] OP_LDR      = mem_ctrl_pkg::OP_LDR,
  parameter logic [OP_W-1:0] OP_STR      = mem_ctrl_pkg::OP_STR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ex_req,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] alu,
  output logic              ex_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state_q;
  kind_t             kind_q;
  logic [DATA_W-1:0] alu_q;
  logic              is_mem;
  logic              mem_accept;
  logic              accept;
  logic              cnt_done;

  assign is_mem     = (opcode == OP_LDR) || (opcode == OP_STR);
  assign mem_accept = (state_q == IDLE) && ex_req && is_mem;
  // A memory request shadows a same-cycle fetch; the held fetch is taken later.
  assign accept     = mem_accept || ((state_q == IDLE) && fetch_req);
  assign ex_ready   = (state_q == IDLE);

  wait_counter #(
    .CNT_W(WAIT_CNT_W)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .load_val_i(WAIT_CNT_W'(WAIT_STATES)),
    .cnt_en_i  (state_q == ACCESS),
    .done_o    (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (mem_accept) begin
      alu_q <= alu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= K_FETCH;
      ram_en      <= 1'b0;
      ram_rw      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_valid <= 1'b0;
          wb_valid    <= 1'b0;
          if (mem_accept) begin
            state_q   <= ACCESS;
            kind_q    <= (opcode == OP_STR) ? K_STORE : K_LOAD;
            ram_en    <= 1'b1;
            ram_rw    <= (opcode == OP_STR);
            ram_addr  <= alu[ADDR_W-1:0];
            ram_wdata <= src1;
          end else begin
            if (ex_req) begin
              wb_valid <= 1'b1;
              wb_data  <= alu;
            end
            if (fetch_req) begin
              state_q  <= ACCESS;
              kind_q   <= K_FETCH;
              ram_en   <= 1'b1;
              ram_rw   <= 1'b0;
              ram_addr <= ADDR_W'(pc);
            end
          end
        end
        ACCESS: begin
          if (cnt_done) begin
            state_q <= COMPLETE;
            ram_en  <= 1'b0;
            ram_rw  <= 1'b0;
            case (kind_q)
              K_FETCH: begin
                fetch_valid <= 1'b1;
                fetch_data  <= ram_rdata;
              end
              K_LOAD: begin
                wb_valid <= 1'b1;
                wb_data  <= ram_rdata;
              end
              default: begin
                wb_valid <= 1'b1;
                wb_data  <= alu_q;
              end
            endcase
          end
        end
        default: begin
          fetch_valid <= 1'b0;
          wb_valid    <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_STATES=1 and hand-computed results.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  pc;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        ex_req;
  logic [3:0]  opcode;
  logic [31:0] src1;
  logic [31:0] alu;
  logic        ex_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        ram_en;
  logic        ram_rw;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(
    .WAIT_STATES(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .ex_req     (ex_req),
    .opcode     (opcode),
    .src1       (src1),
    .alu        (alu),
    .ex_ready   (ex_ready),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .ram_en     (ram_en),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; pc = '0; ex_req = 1'b0;
    opcode = '0; src1 = '0; alu = '0; ram_rdata = '0;
    step(); step();
    checks++; if ({ram_en, ram_rw, fetch_valid, wb_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {ram_en, ram_rw, fetch_valid, wb_valid}); end
    checks++; if ({ram_addr, ram_wdata, fetch_data, wb_data} !== 112'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_wdata, fetch_data, wb_data}); end
    checks++; if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store();
    ex_req = 1'b1; opcode = 4'b1010; src1 = 32'd3; alu = 32'd2;
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++; if ({ram_en, ram_rw, ram_addr, ram_wdata} !== {1'b1, 1'b1, 16'd2, 32'd3}) begin
        errors++; $display("FAIL store_access%0d got en=%b rw=%b addr=%h wdata=%h exp en=1 rw=1 addr=0002 wdata=00000003",
                           c, ram_en, ram_rw, ram_addr, ram_wdata); end
      checks++; if ({ex_ready, wb_valid} !== 2'b00) begin
        errors++; $display("FAIL store_busy%0d got ready/wb=%b exp=00", c, {ex_ready, wb_valid}); end
    end
    step();
    checks++; if ({wb_valid, wb_data, ram_en} !== {1'b1, 32'd2, 1'b0}) begin
      errors++; $display("FAIL store_wb got valid=%b data=%h en=%b exp valid=1 data=00000002 en=0", wb_valid, wb_data, ram_en); end
    ex_req = 1'b0;
    step();
    checks++; if ({wb_valid, wb_data, ex_ready} !== {1'b0, 32'd2, 1'b1}) begin
      errors++; $display("FAIL store_after got valid=%b data=%h ready=%b exp valid=0 data=00000002 ready=1", wb_valid, wb_data, ex_ready); end
  endtask

  task automatic test_load();
    ex_req = 1'b1; opcode = 4'b1001; alu = 32'd2; ram_rdata = 32'd8;
    step();
    checks++; if ({ram_en, ram_rw, ram_addr} !== {1'b1, 1'b0, 16'd2}) begin
      errors++; $display("FAIL load_access got en=%b rw=%b addr=%h exp en=1 rw=0 addr=0002", ram_en, ram_rw, ram_addr); end
    step();
    checks++; if ({ram_en, wb_valid} !== 2'b10) begin
      errors++; $display("FAIL load_wait got en/wb=%b exp=10", {ram_en, wb_valid}); end
    step();
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'd8}) begin
      errors++; $display("FAIL load_wb got valid=%b data=%h exp valid=1 data=00000008", wb_valid, wb_data); end
    ex_req = 1'b0;
    step();
    checks++; if ({wb_valid, wb_data} !== {1'b0, 32'd8}) begin
      errors++; $display("FAIL load_hold got valid=%b data=%h exp valid=0 data=00000008", wb_valid, wb_data); end
  endtask

  task automatic test_bypass();
    ex_req = 1'b1; opcode = 4'b1000; alu = 32'd5;
    step();
    ex_req = 1'b0;
    checks++; if ({wb_valid, wb_data, ram_en, ex_ready} !== {1'b1, 32'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL bypass_wb got valid=%b data=%h en=%b ready=%b exp valid=1 data=00000005 en=0 ready=1",
                         wb_valid, wb_data, ram_en, ex_ready); end
    step();
    checks++; if ({wb_valid, ram_en} !== 2'b00) begin
      errors++; $display("FAIL bypass_after got wb/en=%b exp=00", {wb_valid, ram_en}); end
  endtask

  task automatic test_priority();
    fetch_req = 1'b1; pc = 8'h04;
    ex_req = 1'b1; opcode = 4'b1001; alu = 32'd6; ram_rdata = 32'h0000_00AA;
    step();
    checks++; if ({ram_en, ram_addr} !== {1'b1, 16'd6}) begin
      errors++; $display("FAIL prio_data_first got en=%b addr=%h exp en=1 addr=0006", ram_en, ram_addr); end
    step();
    step();
    checks++; if ({wb_valid, wb_data, fetch_valid} !== {1'b1, 32'hAA, 1'b0}) begin
      errors++; $display("FAIL prio_wb got wb=%b data=%h fv=%b exp wb=1 data=000000aa fv=0", wb_valid, wb_data, fetch_valid); end
    ex_req = 1'b0; ram_rdata = 32'h0000_00BB;
    step();
    checks++; if ({wb_valid, ram_en, ex_ready} !== 3'b001) begin
      errors++; $display("FAIL prio_idle got wb/en/ready=%b exp=001", {wb_valid, ram_en, ex_ready}); end
    step();
    checks++; if ({ram_en, ram_rw, ram_addr} !== {1'b1, 1'b0, 16'd4}) begin
      errors++; $display("FAIL prio_fetch_access got en=%b rw=%b addr=%h exp en=1 rw=0 addr=0004", ram_en, ram_rw, ram_addr); end
    step();
    step();
    checks++; if ({fetch_valid, fetch_data, wb_valid} !== {1'b1, 32'hBB, 1'b0}) begin
      errors++; $display("FAIL prio_fetch got fv=%b data=%h wb=%b exp fv=1 data=000000bb wb=0", fetch_valid, fetch_data, wb_valid); end
    fetch_req = 1'b0;
    step();
    checks++; if ({fetch_valid, fetch_data} !== {1'b0, 32'hBB}) begin
      errors++; $display("FAIL prio_fetch_hold got fv=%b data=%h exp fv=0 data=000000bb", fetch_valid, fetch_data); end
  endtask

  task automatic test_reset_mid_access();
    ex_req = 1'b1; opcode = 4'b1010; src1 = 32'd7; alu = 32'd9;
    step();
    step();
    checks++; if ({ram_en, ram_addr} !== {1'b1, 16'd9}) begin
      errors++; $display("FAIL rstmid_access got en=%b addr=%h exp en=1 addr=0009", ram_en, ram_addr); end
    #3;
    rst = 1'b1; ex_req = 1'b0;
    #1;
    checks++; if ({ram_en, ram_rw, fetch_valid, wb_valid, ram_addr, ram_wdata, fetch_data, wb_data} !== 116'd0) begin
      errors++; $display("FAIL rstmid_async got en=%b rw=%b fv=%b wb=%b addr=%h wdata=%h fdata=%h wdata=%h exp all 0",
                         ram_en, ram_rw, fetch_valid, wb_valid, ram_addr, ram_wdata, fetch_data, wb_data); end
    step();
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid_nowb got wb/ready=%b exp=01", {wb_valid, ex_ready}); end
    rst = 1'b0;
    ex_req = 1'b1; opcode = 4'b1001; alu = 32'h22; ram_rdata = 32'h0000_1234;
    step();
    checks++; if ({ram_en, ram_addr} !== {1'b1, 16'h22}) begin
      errors++; $display("FAIL rstmid_restart got en=%b addr=%h exp en=1 addr=0022", ram_en, ram_addr); end
    step();
    step();
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL rstmid_restart_wb got valid=%b data=%h exp valid=1 data=00001234", wb_valid, wb_data); end
    ex_req = 1'b0;
    step();
  endtask

  task automatic test_addr_trunc();
    ex_req = 1'b1; opcode = 4'b1001; alu = 32'h0001_0003; ram_rdata = 32'h0000_0055;
    step();
    checks++; if ({ram_en, ram_addr} !== {1'b1, 16'h0003}) begin
      errors++; $display("FAIL trunc_addr got en=%b addr=%h exp en=1 addr=0003", ram_en, ram_addr); end
    step();
    step();
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL trunc_wb got valid=%b data=%h exp valid=1 data=00000055", wb_valid, wb_data); end
    ex_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    ex_req = 1'b1; opcode = 4'b0011; alu = 32'h10;
    step();
    alu = 32'h11;
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h10}) begin
      errors++; $display("FAIL b2b_first got valid=%b data=%h exp valid=1 data=00000010", wb_valid, wb_data); end
    step();
    ex_req = 1'b0;
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h11}) begin
      errors++; $display("FAIL b2b_second got valid=%b data=%h exp valid=1 data=00000011", wb_valid, wb_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_bypass();
    test_priority();
    test_reset_mid_access();
    test_addr_trunc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W 32, data/ALU width; ADDR_W 16, RAM address width; PC_W 8, program counter width; OP_W 4, opcode width; WAIT_STATES 1, extra RAM cycles per access (0..15); OP_LDR 4'b1001, load opcode; OP_STR 4'b1010, store opcode.
REQ-002 Ports SHALL be, clock and reset first: clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-003 Fetch request ports SHALL be: fetch_req in 1, instruction fetch request; pc in PC_W, fetch address; fetch_valid out 1, one-cycle fetch-data strobe; fetch_data out DATA_W, fetched word.
REQ-004 Execute request ports SHALL be: ex_req in 1, execute-stage request; opcode in OP_W; src1 in DATA_W, store data; alu in DATA_W, ALU result and data address.
REQ-005 Execute response ports SHALL be: ex_ready out 1, controller can accept a request this cycle; wb_valid out 1, one-cycle writeback strobe; wb_data out DATA_W, load data or ALU result.
REQ-006 RAM ports SHALL be: ram_en out 1, access active; ram_rw out 1, 1=write, 0=read; ram_addr out ADDR_W; ram_wdata out DATA_W; ram_rdata in DATA_W.

Function
REQ-007 States SHALL be IDLE, ACCESS, COMPLETE; ex_ready SHALL be 1 only in IDLE.
REQ-008 In IDLE, ex_req with opcode OP_LDR or OP_STR SHALL start a data access, entering ACCESS next cycle.
REQ-009 In IDLE, ex_req with any other opcode SHALL bypass RAM: wb_valid=1 and wb_data=alu on the next cycle; the state stays IDLE.
REQ-010 In IDLE, fetch_req with no memory ex_req SHALL start a fetch access.
REQ-011 On a same-cycle memory ex_req and fetch_req, the data access SHALL win; the fetch SHALL be served once the controller returns to IDLE, provided fetch_req is still held.
REQ-012 The requester SHALL hold fetch_req, pc, ex_req, opcode, src1 and alu stable until its strobe arrives; the controller SHALL latch all request fields at acceptance.
REQ-013 In ACCESS, ram_en SHALL be 1 and ram_addr SHALL be the zero-extended pc for a fetch, or alu[ADDR_W-1:0] for a data access.
REQ-014 In ACCESS, ram_rw SHALL be 1 only for OP_STR, and ram_wdata SHALL be the latched src1.
REQ-015 ACCESS SHALL last exactly WAIT_STATES+1 cycles, counted by a wait counter loaded at entry; ram_rdata SHALL be sampled in the last ACCESS cycle.
REQ-016 In COMPLETE, the controller SHALL pulse one strobe for one cycle, then return to IDLE: fetch_valid with fetch_data=ram_rdata for a fetch; wb_valid with wb_data=ram_rdata for a load; wb_valid with wb_data=latched alu for a store.
REQ-017 With WAIT_STATES=0, total latency from acceptance to strobe SHALL be 2 cycles, and WAIT_STATES+2 in general.
REQ-018 fetch_data and wb_data SHALL hold their last value when not strobed; ram_en SHALL be 0 outside ACCESS.
REQ-019 If alu exceeds the ADDR_W range, its upper bits SHALL be discarded silently, with no error flag.
REQ-020 Requests arriving while ex_ready=0 SHALL be ignored and not queued, except for the held fetch priority described in REQ-011.

Reset
REQ-021 Asserting rst SHALL immediately force state IDLE, wait counter 0, ram_en 0, ram_rw 0, ram_addr 0, ram_wdata 0, fetch_valid 0, wb_valid 0, fetch_data 0 and wb_data 0.
REQ-022 When rst is asserted during ACCESS, the access SHALL be abandoned, no strobe SHALL be issued, and requests SHALL be accepted again on the first clk edge after rst deasserts.

Structure
REQ-023 A shared package mem_ctrl_pkg SHALL hold the state enum, OP_LDR and OP_STR, and the default widths.
REQ-024 The wait counter SHALL be a sub-module wait_counter with load, count-enable and a done output.

Verification
REQ-025 Bench SHALL drive, with WAIT_STATES=1, a store: opcode 1010, src1=3, alu=2 -> ram_en=1, ram_rw=1, ram_addr=2, ram_wdata=3 for 2 cycles, then wb_valid with wb_data=2.
REQ-026 Bench SHALL drive a load: opcode 1001, alu=2, ram_rdata=8 -> ram_rw=0, ram_addr=2, then wb_valid with wb_data=8, three cycles after acceptance.
REQ-027 Bench SHALL drive a bypass: opcode 1000, alu=5 -> wb_valid with wb_data=5 on the next cycle and ram_en held at 0.
REQ-028 Bench SHALL drive a simultaneous fetch_req with pc=8'h04 and load alu=6 -> ram_addr=6 is served first, then ram_addr=4, and fetch_valid follows wb_valid.
REQ-029 Bench SHALL assert rst during the second ACCESS cycle of a store -> all outputs go to 0 asynchronously, with no wb_valid.
REQ-030 Bench SHALL drive alu=32'h0001_0003 with ADDR_W=16 -> ram_addr=16'h0003.
